// File: rtl/minmax_stream_tracker.sv
// Framed min/max/sum tracker: accepts len samples over valid/ready and reports
// running extremes with first-occurrence indices, running sum and sample count.
module minmax_stream_tracker #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       len,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       min,
  output logic [WIDTH-1:0]       max,
  output logic [CNT_W-1:0]       min_idx,
  output logic [CNT_W-1:0]       max_idx,
  output logic [WIDTH+CNT_W-1:0] sum,
  output logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   done
);

  localparam int SUM_W = WIDTH + CNT_W;
  localparam logic [WIDTH-1:0] MAXV = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MINV = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [CNT_W-1:0] r_minIdx;
  logic [CNT_W-1:0] r_maxIdx;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_inReady;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_less;
  logic             w_greater;
  logic             w_last;
  logic [SUM_W-1:0] w_ext;

  assign w_accept  = (r_state == S_RUN) && in_valid;
  assign w_less    = SIGNED ? ($signed(in_data) < $signed(r_min)) : (in_data < r_min);
  assign w_greater = SIGNED ? ($signed(in_data) > $signed(r_max)) : (in_data > r_max);
  assign w_last    = (r_count == (r_len - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign w_ext     = SIGNED ? {{CNT_W{in_data[WIDTH-1]}}, in_data} : {{CNT_W{1'b0}}, in_data};

  // Strict compares keep the earliest index on ties; a zero-length start goes straight to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_min     <= MAXV;
      r_max     <= MINV;
      r_minIdx  <= '0;
      r_maxIdx  <= '0;
      r_sum     <= '0;
      r_count   <= '0;
      r_inReady <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len    <= len;
            r_min    <= MAXV;
            r_max    <= MINV;
            r_minIdx <= '0;
            r_maxIdx <= '0;
            r_sum    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            if (len != '0) begin
              r_state   <= S_RUN;
              r_inReady <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_less) begin
              r_min    <= in_data;
              r_minIdx <= r_count;
            end
            if (w_greater) begin
              r_max    <= in_data;
              r_maxIdx <= r_count;
            end
            r_sum   <= r_sum + w_ext;
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_state   <= S_DONE;
              r_inReady <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_inReady <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_inReady <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_inReady;
  assign min      = r_min;
  assign max      = r_max;
  assign min_idx  = r_minIdx;
  assign max_idx  = r_maxIdx;
  assign sum      = r_sum;
  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
